// File: rtl/fifo_pkg.sv
// Shared defaults and mode encoding for the synchronous FIFO buffer.
// Imported by fifo_sync_ram and fifo_sync_buffer.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 12;
    localparam int FIFO_DEPTH_DEF  = 32;

    typedef enum logic {
        FIFO_BYPASS = 1'b0,
        FIFO_BUFFER = 1'b1
    } fifo_mode_e;

    function automatic fifo_mode_e to_mode(input logic fifo_en);
        return fifo_en ? FIFO_BUFFER : FIFO_BYPASS;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Storage array for fifo_sync_buffer: one write port, one registered read port.
// The read register only loads on rd_en, so it holds the last word popped.
module fifo_sync_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH_DEF)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_W];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // NOTE: the array and its read register carry no reset so the tools can map them onto RAM.
    // A same-address read and write returns the old word, which is what a full FIFO needs.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync_buffer.sv
// Single-clock FIFO with pointers, occupancy flags, registered read port, bypass and flush.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAG_EN is defined.
module fifo_sync_buffer
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int ADDRBIT    = $clog2(FIFO_DEPTH),
    parameter int  AFULL_LVL  = FIFO_DEPTH - 4,
    parameter int  AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_en,
    input  logic                  flush,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rd_valid,
    output logic                  fifofull,
    output logic                  notempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDRBIT:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int             CW       = ADDRBIT + 1;
    localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0]  AEMPTY_C = CW'(AEMPTY_LVL);

    fifo_mode_e mode;
    logic       is_buf;
    logic       acc_wr;
    logic       acc_rd;

    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
    logic                  sel_ram_q, sel_ram_d;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign mode   = to_mode(fifo_en);
    assign is_buf = (mode == FIFO_BUFFER);

    // Flags decode straight from the registered count.
    assign fifofull     = (count_q == DEPTH_C);
    assign notempty     = (count_q != '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);

    assign acc_rd = is_buf & read_en & notempty;
    assign acc_wr = is_buf & write_en & (!fifofull | acc_rd);

    // NOTE: every _d is given its hold value first so no latch can be inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        byp_data_d = byp_data_q;
        sel_ram_d  = sel_ram_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (!is_buf) begin
            byp_data_d = write_data;
            sel_ram_d  = 1'b0;
            rd_valid_d = write_en;
        end else begin
            if (acc_wr) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (acc_rd) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                sel_ram_d  = 1'b1;
                rd_valid_d = 1'b1;
            end
            count_d = count_q + CW'(acc_wr) - CW'(acc_rd);
        end
    end

    // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            byp_data_q <= '0;
            sel_ram_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            byp_data_q <= byp_data_d;
            sel_ram_q  <= sel_ram_d;
        end
    end

    fifo_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDRBIT)
    ) u_ram (
        .clk     (clk),
        .wr_en   (acc_wr & !flush),
        .wr_addr (wr_ptr_q[ADDRBIT-1:0]),
        .wr_data (write_data),
        .rd_en   (acc_rd & !flush),
        .rd_addr (rd_ptr_q[ADDRBIT-1:0]),
        .rd_data (ram_rdata)
    );

    // sel_ram_q remembers which register last loaded; reset selects the zeroed bypass register.
    assign read_data = sel_ram_q ? ram_rdata : byp_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;

`ifdef FIFO_ERR_FLAG_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (is_buf & write_en & fifofull & !acc_rd) begin
                overflow_d = 1'b1;
            end
            if (is_buf & read_en & !notempty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_buffer.sv
// Directed self-checking bench for fifo_sync_buffer (DATA_WIDTH=12, FIFO_DEPTH=32).
// Error-flag expectations follow FIFO_ERR_FLAG_EN.
module tb_fifo_sync_buffer;

`ifdef FIFO_ERR_FLAG_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        fifo_en;
    logic        flush;
    logic        write_en;
    logic [11:0] write_data;
    logic        read_en;
    logic [11:0] read_data;
    logic        rd_valid;
    logic        fifofull;
    logic        notempty;
    logic        almost_full;
    logic        almost_empty;
    logic [5:0]  count;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_sync_buffer #(
        .DATA_WIDTH (12),
        .FIFO_DEPTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_en      (fifo_en),
        .flush        (flush),
        .write_en     (write_en),
        .write_data   (write_data),
        .read_en      (read_en),
        .read_data    (read_data),
        .rd_valid     (rd_valid),
        .fifofull     (fifofull),
        .notempty     (notempty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected summary before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // Apply one cycle of inputs, then sample 1 time unit after the edge that consumed them.
    task automatic step(input logic en, input logic we, input logic [11:0] wd,
                        input logic re, input logic fl);
        fifo_en    = en;
        write_en   = we;
        write_data = wd;
        read_en    = re;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        fifo_en = 1'b1; flush = 1'b0; write_en = 1'b0; write_data = '0; read_en = 1'b0;
        #12;
        n_checks++;
        if (count !== 6'd0 || notempty !== 1'b0 || fifofull !== 1'b0 ||
            almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got count=%0d ne=%b ff=%b ae=%b af=%b, expected 0 0 0 1 0",
                     count, notempty, fifofull, almost_empty, almost_full);
        end
        n_checks++;
        if (read_data !== 12'h000 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%h v=%b ovf=%b udf=%b, expected 000 0 0 0",
                     read_data, rd_valid, overflow, underflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fill_drain;
        for (int i = 1; i <= 32; i++) begin
            step(1'b1, 1'b1, 12'(i), 1'b0, 1'b0);
            n_checks++;
            if (count !== 6'(i) || fifofull !== (i == 32) || almost_full !== (i >= 28) ||
                almost_empty !== (i <= 2) || notempty !== 1'b1) begin
                n_fail++;
                $display("FAIL fill[%0d]: got count=%0d ff=%b af=%b ae=%b ne=%b, expected count=%0d ff=%b af=%b ae=%b ne=1",
                         i, count, fifofull, almost_full, almost_empty, notempty,
                         i, (i == 32), (i >= 28), (i <= 2));
            end
        end
        for (int i = 1; i <= 32; i++) begin
            step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
            n_checks++;
            if (rd_valid !== 1'b1 || read_data !== 12'(i) || count !== 6'(32 - i)) begin
                n_fail++;
                $display("FAIL drain[%0d]: got v=%b rd=%h count=%0d, expected v=1 rd=%h count=%0d",
                         i, rd_valid, read_data, count, 12'(i), 32 - i);
            end
        end
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b0 || notempty !== 1'b0 || almost_empty !== 1'b1 || read_data !== 12'h020) begin
            n_fail++;
            $display("FAIL drain_end: got v=%b ne=%b ae=%b rd=%h, expected v=0 ne=0 ae=1 rd=020",
                     rd_valid, notempty, almost_empty, read_data);
        end
    endtask

    task automatic test_full_wrap;
        for (int i = 1; i <= 32; i++) begin
            step(1'b1, 1'b1, 12'(i), 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 12'hABC, 1'b1, 1'b0);
        n_checks++;
        if (count !== 6'd32 || fifofull !== 1'b1 || read_data !== 12'h001 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_simul: got count=%0d ff=%b rd=%h v=%b, expected count=32 ff=1 rd=001 v=1",
                     count, fifofull, read_data, rd_valid);
        end
        for (int i = 2; i <= 32; i++) begin
            step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
            n_checks++;
            if (read_data !== 12'(i) || rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_read[%0d]: got rd=%h v=%b, expected rd=%h v=1",
                         i, read_data, rd_valid, 12'(i));
            end
        end
        step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        n_checks++;
        if (read_data !== 12'hABC || count !== 6'd0) begin
            n_fail++;
            $display("FAIL wrap_last: got rd=%h count=%0d, expected rd=abc count=0", read_data, count);
        end
    endtask

    task automatic test_empty_simul;
        step(1'b1, 1'b1, 12'h555, 1'b1, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 6'd1 || read_data !== 12'hABC) begin
            n_fail++;
            $display("FAIL empty_simul: got v=%b count=%0d rd=%h, expected v=0 count=1 rd=abc",
                     rd_valid, count, read_data);
        end
        step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b1 || read_data !== 12'h555 || count !== 6'd0) begin
            n_fail++;
            $display("FAIL empty_followup: got v=%b rd=%h count=%0d, expected v=1 rd=555 count=0",
                     rd_valid, read_data, count);
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 12'(12'h100 + i), 1'b0, 1'b0);
        end
        n_checks++;
        if (count !== 6'd5) begin
            n_fail++;
            $display("FAIL flush_pre: got count=%0d, expected 5", count);
        end
        step(1'b1, 1'b1, 12'h777, 1'b1, 1'b1);
        n_checks++;
        if (count !== 6'd0 || notempty !== 1'b0 || rd_valid !== 1'b0 || read_data !== 12'h555 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got count=%0d ne=%b v=%b rd=%h ovf=%b udf=%b, expected 0 0 0 555 0 0",
                     count, notempty, rd_valid, read_data, overflow, underflow);
        end
        step(1'b1, 1'b1, 12'h888, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        n_checks++;
        if (read_data !== 12'h888 || rd_valid !== 1'b1 || count !== 6'd0) begin
            n_fail++;
            $display("FAIL flush_after: got rd=%h v=%b count=%0d, expected rd=888 v=1 count=0",
                     read_data, rd_valid, count);
        end
    endtask

    task automatic test_bypass;
        logic [11:0] stored [3];
        stored[0] = 12'h011; stored[1] = 12'h022; stored[2] = 12'h033;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, stored[i], 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 12'h3C3, 1'b1, 1'b0);
        n_checks++;
        if (read_data !== 12'h3C3 || rd_valid !== 1'b1 || count !== 6'd3) begin
            n_fail++;
            $display("FAIL bypass_write: got rd=%h v=%b count=%0d, expected rd=3c3 v=1 count=3",
                     read_data, rd_valid, count);
        end
        step(1'b0, 1'b0, 12'h0AA, 1'b0, 1'b0);
        n_checks++;
        if (read_data !== 12'h0AA || rd_valid !== 1'b0 || count !== 6'd3) begin
            n_fail++;
            $display("FAIL bypass_idle: got rd=%h v=%b count=%0d, expected rd=0aa v=0 count=3",
                     read_data, rd_valid, count);
        end
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        n_checks++;
        if (read_data !== 12'h0AA || rd_valid !== 1'b0 || count !== 6'd3) begin
            n_fail++;
            $display("FAIL bypass_resume: got rd=%h v=%b count=%0d, expected rd=0aa v=0 count=3",
                     read_data, rd_valid, count);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
            n_checks++;
            if (read_data !== stored[i] || rd_valid !== 1'b1 || count !== 6'(2 - i)) begin
                n_fail++;
                $display("FAIL bypass_stored[%0d]: got rd=%h v=%b count=%0d, expected rd=%h v=1 count=%0d",
                         i, read_data, rd_valid, count, stored[i], 2 - i);
            end
        end
    endtask

    task automatic test_errors;
        for (int i = 1; i <= 32; i++) begin
            step(1'b1, 1'b1, 12'(i), 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== ERR_EN || underflow !== 1'b0 || count !== 6'd32) begin
            n_fail++;
            $display("FAIL overflow_set: got ovf=%b udf=%b count=%0d, expected ovf=%b udf=0 count=32",
                     overflow, underflow, count, ERR_EN);
        end
        for (int i = 1; i <= 32; i++) begin
            step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        end
        n_checks++;
        if (read_data !== 12'h020 || overflow !== ERR_EN) begin
            n_fail++;
            $display("FAIL overflow_drop: got rd=%h ovf=%b, expected rd=020 ovf=%b",
                     read_data, overflow, ERR_EN);
        end
        step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        n_checks++;
        if (underflow !== ERR_EN || rd_valid !== 1'b0 || read_data !== 12'h020) begin
            n_fail++;
            $display("FAIL underflow_set: got udf=%b v=%b rd=%h, expected udf=%b v=0 rd=020",
                     underflow, rd_valid, read_data, ERR_EN);
        end
        step(1'b1, 1'b1, 12'h0F0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        n_checks++;
        if (read_data !== 12'h0F0 || overflow !== ERR_EN || underflow !== ERR_EN) begin
            n_fail++;
            $display("FAIL error_sticky: got rd=%h ovf=%b udf=%b, expected rd=0f0 ovf=%b udf=%b",
                     read_data, overflow, underflow, ERR_EN, ERR_EN);
        end
        step(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL error_flush: got ovf=%b udf=%b, expected 0 0", overflow, underflow);
        end
        step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        n_checks++;
        if (underflow !== ERR_EN) begin
            n_fail++;
            $display("FAIL underflow_reset_pre: got udf=%b, expected %b", underflow, ERR_EN);
        end
        read_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (underflow !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL error_rst: got ovf=%b udf=%b, expected 0 0", overflow, underflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_async_reset;
        step(1'b1, 1'b1, 12'h201, 1'b0, 1'b0);
        step(1'b1, 1'b1, 12'h202, 1'b0, 1'b0);
        step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b1 || read_data !== 12'h201) begin
            n_fail++;
            $display("FAIL async_pre: got v=%b rd=%h, expected v=1 rd=201", rd_valid, read_data);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || read_data !== 12'h000 || count !== 6'd0 ||
            notempty !== 1'b0 || almost_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst: got v=%b rd=%h count=%0d ne=%b ae=%b, expected 0 000 0 0 1",
                     rd_valid, read_data, count, notempty, almost_empty);
        end
        read_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 6'd0 || read_data !== 12'h000) begin
            n_fail++;
            $display("FAIL async_post: got v=%b count=%0d rd=%h, expected v=0 count=0 rd=000",
                     rd_valid, count, read_data);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_wrap();
        test_empty_simul();
        test_flush();
        test_bypass();
        test_errors();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_buffer.md
Name: fifo_sync_buffer

Overview:
- Parametrised single-clock FIFO buffer for the read-memory datapath. It is the successor to the existing address-driven FIFO storage block.
- Owns its own read and write pointers, occupancy count, and full/empty/almost flags, so upstream no longer supplies addresses or flags.
- Provides a registered read port with a valid strobe, a bypass mode, and a synchronous flush.
- Sits between the sample producer and the memory-read consumer.

Parameters:
- DATA_WIDTH, 12, width of each data word.
- FIFO_DEPTH, 32, number of entries; must be a power of two and at least 4.
- ADDRBIT, $clog2(FIFO_DEPTH), pointer index width; derived, not overridden.
- AFULL_LVL, FIFO_DEPTH-4, almost_full asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 2, almost_empty asserts when count <= AEMPTY_LVL.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- fifo_en  in  1  1 = FIFO mode, 0 = bypass mode.
- flush  in  1  synchronous clear of pointers and count.
- write_en  in  1  push request.
- write_data  in  DATA_WIDTH  push data.
- read_en  in  1  pop request.
- read_data  out  DATA_WIDTH  registered pop data.
- rd_valid  out  1  read_data updated this cycle.
- fifofull  out  1  count == FIFO_DEPTH.
- notempty  out  1  count != 0.
- almost_full  out  1  count >= AFULL_LVL.
- almost_empty  out  1  count <= AEMPTY_LVL.
- count  out  ADDRBIT+1  current occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky error: write dropped (optional feature).
- underflow  out  1  sticky error: read of empty FIFO (optional feature).

Behaviour:
- Reset values (rst=1, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0.
  - read_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Resulting flags: notempty = 0, fifofull = 0, almost_empty = 1, almost_full = 0.
  - Memory array is not reset (allows RAM inference); its contents are don't-care after reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDRBIT+1 bits wide; the MSB is the wrap bit.
  - Storage index = ptr[ADDRBIT-1:0]; natural modulo wrap at FIFO_DEPTH.
- Flags:
  - All flags decode combinationally from the registered count.
  - Flags are valid in the same cycle that count updates.
- Accepted operations:
  - Write accepted: acc_wr = fifo_en & write_en & (!fifofull | acc_rd).
  - Read accepted: acc_rd = fifo_en & read_en & notempty.
- Accepted write: mem[wr_ptr] <= write_data; wr_ptr += 1.
- Accepted read (latency 1 cycle):
  - read_data <= mem[rd_ptr]; rd_ptr += 1; rd_valid = 1 on the following cycle.
  - When no read is accepted, rd_valid = 0 and read_data holds its previous value.
- Count update: count += acc_wr - acc_rd.
- Simultaneous write and read:
  - When full: both are accepted, count stays at FIFO_DEPTH, and the oldest entry is read.
  - When empty: the read is rejected, the write is accepted, count becomes 1. There is no fall-through; the new word is readable from the next cycle.
- Rejected operations:
  - Write while full without a read: dropped; memory and pointers unchanged.
  - Read while empty: ignored; read_data held, rd_valid = 0.
- Flush:
  - flush = 1 (either mode): wr_ptr = rd_ptr = 0, count = 0, rd_valid = 0, and overflow/underflow are cleared.
  - Flush has priority over a same-cycle write or read.
  - read_data holds its value.
- Bypass mode (fifo_en = 0):
  - read_data <= write_data every cycle; rd_valid <= write_en.
  - Pointers, count and memory are frozen, so stored contents survive.
  - Re-entering FIFO mode resumes from the frozen state.
- Reset mid-operation: asynchronous reset aborts any in-flight read; outputs go to their reset values immediately.

Optional Feature:
- Macro: FIFO_ERR_FLAG_EN.
- With the macro defined:
  - overflow sets when fifo_en & write_en & fifofull & !acc_rd.
  - underflow sets when fifo_en & read_en & !notempty.
  - Both are sticky until flush or rst.
- Without the macro: overflow and underflow are tied to 0 and no error logic is built. Ports remain present.

Decomposition:
- Package fifo_pkg holds:
  - the default constants (FIFO_DATA_WIDTH = 12, FIFO_DEPTH_DEF = 32);
  - an enum fifo_mode_e {FIFO_BYPASS, FIFO_BUFFER}, which fifo_en maps onto.
- Sub-module fifo_sync_ram holds the storage array only:
  - one write port;
  - one registered read port;
  - no reset on the array.
- Top level holds pointers, count, flags, bypass mux and the error flags.

Test Plan (DATA_WIDTH = 12, FIFO_DEPTH = 32):
1. Reset, then write 0x001..0x020 (32 words), then read 32 times:
   - fifofull = 1 after the 32nd write;
   - read_data sequence is 0x001..0x020, each with rd_valid one cycle after read_en;
   - notempty = 0 at the end.
2. Full, then simultaneous write of 0xABC and a read:
   - count stays 32, read_data = 0x001;
   - 0xABC emerges after 31 further reads (wrap-around check).
3. Empty, then simultaneous write of 0x555 and a read:
   - rd_valid = 0, count = 1;
   - a read on the next cycle returns 0x555.
4. Write 5 words, then flush with a same-cycle write:
   - count = 0, notempty = 0;
   - with FIFO_ERR_FLAG_EN, overflow and underflow are 0.
5. fifo_en = 0 with write_data = 0x3C3, write_en = 1:
   - read_data = 0x3C3 and rd_valid = 1 on the next cycle;
   - count unchanged;
   - after fifo_en = 1, previously stored words read out intact.
6. With FIFO_ERR_FLAG_EN, write while full and read while empty:
   - overflow and underflow set and stay set across normal traffic;
   - both clear on flush or rst.
